// File: rtl/alu_cmd_seq_pkg.sv
// alu_cmd_seq_pkg: shared widths, state encoding and opcodes for the ALU command sequencer
package alu_cmd_seq_pkg;
  localparam int DW = 4;
  localparam int SELW = 3;
  localparam int NREG = 4;
  localparam int AW = $clog2(NREG);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic OP_ALU = 1'b0;
  localparam logic OP_LOAD = 1'b1;
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: valid/ready command bundle feeding the sequencer
interface alu_cmd_sequencer_if #(
  parameter int DW = alu_cmd_seq_pkg::DW,
  parameter int SELW = alu_cmd_seq_pkg::SELW,
  parameter int AW = alu_cmd_seq_pkg::AW
);
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_op;
  logic [SELW-1:0] cmd_sel;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [AW-1:0] cmd_rd;
  logic cmd_imm_en;
  logic [DW-1:0] cmd_imm;
  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_ra, cmd_rb, cmd_rd, cmd_imm_en, cmd_imm,
    input cmd_ready
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_sel, cmd_ra, cmd_rb, cmd_rd, cmd_imm_en, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/alu_cmd_regfile.sv
// alu_cmd_regfile: NREG x DW register file, two operand read ports, one debug read port, one write port
module alu_cmd_regfile #(
  parameter int DW = alu_cmd_seq_pkg::DW,
  parameter int NREG = alu_cmd_seq_pkg::NREG,
  localparam int AW = $clog2(NREG)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];
  always_comb begin
    for (int i = 0; i < NREG; i++) mem_d[i] = we && waddr == AW'(i) ? wdata : mem_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
  assign dbg_data = mem_q[dbg_addr];
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts commands, drives an external ALU from a register file,
// writes the result back and keeps sticky carry/zero flags
module alu_cmd_sequencer #(
  parameter int DW = alu_cmd_seq_pkg::DW,
  parameter int NREG = alu_cmd_seq_pkg::NREG,
  parameter int SELW = alu_cmd_seq_pkg::SELW,
  localparam int AW = $clog2(NREG)
) (
  input  logic clk,
  input  logic rst_n,
  alu_cmd_sequencer_if.slave cmd,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SELW-1:0] alu_sel,
  input  logic [DW-1:0] alu_result,
  input  logic alu_carry,
  input  logic alu_zero,
  output logic done_valid,
  output logic [DW-1:0] done_result,
  output logic flag_c,
  output logic flag_z,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  import alu_cmd_seq_pkg::*;
  state_t state_q, state_d;
  logic op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SELW-1:0] alu_sel_q, alu_sel_d;
  logic done_valid_q, done_valid_d;
  logic [DW-1:0] done_result_q, done_result_d;
  logic flag_c_q, flag_c_d, flag_z_q, flag_z_d;
  logic [DW-1:0] rf_a, rf_b, wr_data;
  logic accept, accept_alu, exec;
  assign cmd.cmd_ready = state_q == IDLE;
  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign accept_alu = accept && cmd.cmd_op == OP_ALU;
  assign exec = state_q == EXEC;
  assign wr_data = op_q == OP_LOAD ? imm_q : alu_result;
  alu_cmd_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk(clk),
    .rst_n(rst_n),
    .we(exec),
    .waddr(rd_q),
    .wdata(wr_data),
    .raddr_a(cmd.cmd_ra),
    .rdata_a(rf_a),
    .raddr_b(cmd.cmd_rb),
    .rdata_b(rf_b),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );
  // Writes happen only in EXEC while cmd_ready is low, so operands read at accept never need forwarding
  always_comb begin
    state_d = accept ? EXEC : exec ? DONE : IDLE;
    op_d = accept ? cmd.cmd_op : op_q;
    rd_d = accept ? cmd.cmd_rd : rd_q;
    imm_d = accept ? cmd.cmd_imm : imm_q;
    alu_a_d = accept_alu ? rf_a : alu_a_q;
    alu_b_d = accept_alu ? (cmd.cmd_imm_en ? cmd.cmd_imm : rf_b) : alu_b_q;
    alu_sel_d = accept_alu ? cmd.cmd_sel : alu_sel_q;
    done_valid_d = exec;
    done_result_d = exec ? wr_data : done_result_q;
    flag_c_d = exec && op_q == OP_ALU ? alu_carry : flag_c_q;
    flag_z_d = exec ? (op_q == OP_LOAD ? imm_q == '0 : alu_zero) : flag_z_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= OP_ALU;
      rd_q <= '0;
      imm_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_sel_q <= '0;
      done_valid_q <= 1'b0;
      done_result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rd_q <= rd_d;
      imm_q <= imm_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      done_valid_q <= done_valid_d;
      done_result_q <= done_result_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign done_valid = done_valid_q;
  assign done_result = done_result_q;
  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed commands with a scoreboard of expected retirements
module tb_alu_cmd_sequencer;
  import alu_cmd_seq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_cmd_sequencer_if #(.DW(DW), .SELW(SELW), .AW(AW)) cmd_if ();
  logic [DW-1:0] alu_a, alu_b, alu_result, done_result, dbg_data;
  logic [SELW-1:0] alu_sel;
  logic alu_carry, alu_zero, done_valid, flag_c, flag_z;
  logic [AW-1:0] dbg_addr;
  logic [DW:0] sum;
  assign sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = alu_sel == '0 ? sum[DW-1:0] : alu_a ^ alu_b;
  assign alu_carry = alu_sel == '0 && sum[DW];
  assign alu_zero = alu_result == '0;
  alu_cmd_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd(cmd_if),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_sel(alu_sel),
    .alu_result(alu_result),
    .alu_carry(alu_carry),
    .alu_zero(alu_zero),
    .done_valid(done_valid),
    .done_result(done_result),
    .flag_c(flag_c),
    .flag_z(flag_z),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );
  typedef struct packed {
    logic [3:0] res;
    logic c;
    logic z;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc = -10;
  int n_acc = 0;
  int t0, a0;
  logic prev_done = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    if (rst_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      last_acc = cyc;
      n_acc++;
    end
  end
  always @(negedge clk) begin
    if (rst_n && done_valid) begin
      chk("done_pulse_width", {31'd0, prev_done}, 0);
      chk("done_latency", cyc - last_acc, 1);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_unexpected: got done_result %0h with no command pending", done_result);
      end else begin
        e = sb.pop_front();
        chk("done_result", {28'd0, done_result}, {28'd0, e.res});
        chk("flag_c", {31'd0, flag_c}, {31'd0, e.c});
        chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
      end
    end
    prev_done = done_valid;
  end
  task automatic issue(input logic op, input logic [2:0] sel, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, input logic imm_en, input logic [3:0] imm, input logic keep,
                       input logic push, input exp_t ex);
    int n = 0;
    cmd_if.cmd_op = op;
    cmd_if.cmd_sel = sel;
    cmd_if.cmd_ra = ra;
    cmd_if.cmd_rb = rb;
    cmd_if.cmd_rd = rd;
    cmd_if.cmd_imm_en = imm_en;
    cmd_if.cmd_imm = imm;
    cmd_if.cmd_valid = 1'b1;
    if (push) sb.push_back(ex);
    while (!cmd_if.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", n, 0);
    @(posedge clk);
    @(negedge clk);
    if (!keep) cmd_if.cmd_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!cmd_if.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("idle_timeout", n, 0);
  endtask
  task automatic dbg_chk(input int a, input logic [3:0] ex);
    dbg_addr = 2'(a);
    #1;
    chk($sformatf("dbg_r%0d", a), {28'd0, dbg_data}, {28'd0, ex});
  endtask
  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op = OP_ALU;
    cmd_if.cmd_sel = '0;
    cmd_if.cmd_ra = '0;
    cmd_if.cmd_rb = '0;
    cmd_if.cmd_rd = '0;
    cmd_if.cmd_imm_en = 1'b0;
    cmd_if.cmd_imm = '0;
    dbg_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_if.cmd_ready}, 1);
    chk("rst_alu_a", {28'd0, alu_a}, 0);
    chk("rst_alu_b", {28'd0, alu_b}, 0);
    chk("rst_alu_sel", {29'd0, alu_sel}, 0);
    chk("rst_done_valid", {31'd0, done_valid}, 0);
    chk("rst_done_result", {28'd0, done_result}, 0);
    chk("rst_flag_c", {31'd0, flag_c}, 0);
    chk("rst_flag_z", {31'd0, flag_z}, 0);
    for (int i = 0; i < 4; i++) dbg_chk(i, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_LOAD, 3'd0, 2'd0, 2'd0, 2'd1, 1'b0, 4'h9, 1'b0, 1'b1, '{4'h9, 1'b0, 1'b0});
    wait_idle();
    issue(OP_LOAD, 3'd0, 2'd0, 2'd0, 2'd2, 1'b0, 4'h7, 1'b0, 1'b1, '{4'h7, 1'b0, 1'b0});
    wait_idle();
    dbg_chk(1, 4'h9);
    dbg_chk(2, 4'h7);
    issue(OP_ALU, 3'd0, 2'd1, 2'd2, 2'd3, 1'b0, 4'h0, 1'b0, 1'b1, '{4'h0, 1'b1, 1'b1});
    chk("exec_alu_a", {28'd0, alu_a}, 9);
    chk("exec_alu_b", {28'd0, alu_b}, 7);
    chk("exec_alu_sel", {29'd0, alu_sel}, 0);
    chk("exec_cmd_ready", {31'd0, cmd_if.cmd_ready}, 0);
    wait_idle();
    dbg_chk(3, 4'h0);
    issue(OP_ALU, 3'd1, 2'd1, 2'd1, 2'd1, 1'b0, 4'h0, 1'b0, 1'b1, '{4'h0, 1'b0, 1'b1});
    wait_idle();
    dbg_chk(1, 4'h0);
    issue(OP_ALU, 3'd0, 2'd1, 2'd3, 2'd0, 1'b1, 4'hF, 1'b0, 1'b1, '{4'hF, 1'b0, 1'b0});
    chk("imm_alu_b", {28'd0, alu_b}, 4'hF);
    wait_idle();
    dbg_chk(0, 4'hF);
    a0 = n_acc;
    issue(OP_LOAD, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'h5, 1'b1, 1'b1, '{4'h5, 1'b0, 1'b0});
    t0 = last_acc;
    issue(OP_ALU, 3'd2, 2'd0, 2'd3, 2'd1, 1'b0, 4'h0, 1'b1, 1'b1, '{4'h5, 1'b0, 1'b0});
    chk("burst_spacing1", last_acc - t0, 3);
    chk("burst_alu_a", {28'd0, alu_a}, 5);
    t0 = last_acc;
    issue(OP_ALU, 3'd0, 2'd0, 2'd0, 2'd2, 1'b1, 4'hB, 1'b0, 1'b1, '{4'h0, 1'b1, 1'b1});
    chk("burst_spacing2", last_acc - t0, 3);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("burst_accepts", n_acc - a0, 3);
    dbg_chk(0, 4'h5);
    dbg_chk(1, 4'h5);
    dbg_chk(2, 4'h0);
    issue(OP_LOAD, 3'd0, 2'd0, 2'd0, 2'd3, 1'b0, 4'h0, 1'b0, 1'b1, '{4'h0, 1'b1, 1'b1});
    wait_idle();
    issue(OP_ALU, 3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 4'h0, 1'b0, 1'b0, '{4'h0, 1'b0, 1'b0});
    chk("pre_rst_alu_a", {28'd0, alu_a}, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_done_valid", {31'd0, done_valid}, 0);
    chk("midrst_cmd_ready", {31'd0, cmd_if.cmd_ready}, 1);
    chk("midrst_alu_a", {28'd0, alu_a}, 0);
    chk("midrst_flag_c", {31'd0, flag_c}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("postrst_done_valid", {31'd0, done_valid}, 0);
    chk("postrst_cmd_ready", {31'd0, cmd_if.cmd_ready}, 1);
    dbg_chk(2, 4'h0);
    issue(OP_LOAD, 3'd0, 2'd0, 2'd0, 2'd2, 1'b0, 4'h3, 1'b0, 1'b1, '{4'h3, 1'b0, 1'b0});
    wait_idle();
    dbg_chk(2, 4'h3);
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
